// File: rtl/imm_encoder_pkg.sv
// -----------------------------------------------------------------------------
// imm_encoder_pkg
// Shared immediate-format definitions used by the immediate encoder, extender
// and decoder.
//   imm_src_t      : ImmSrc format code (I, S, B, U, J; 101-111 are illegal)
//   IMM*_MIN/MAX   : signed range limits of each immediate format
// -----------------------------------------------------------------------------
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_t;

    // 12-bit signed immediate (I and S formats)
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    // 13-bit signed, even byte offset (B format)
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    // 21-bit signed, even byte offset (J format)
    localparam int IMMJ_MIN  = -(1 << 20);
    localparam int IMMJ_MAX  = (1 << 20) - 2;

endpackage

// File: rtl/imm_range_check.sv
// -----------------------------------------------------------------------------
// imm_range_check
// Combinational check that an immediate is representable in a given format.
//   ImmSrc : input  [2:0]  format code (imm_src_t encoding, 101-111 illegal)
//   ImmIn  : input  [31:0] signed immediate, two's complement
//   err    : output        1 when the immediate does not fit the format or the
//                          format code is illegal
// -----------------------------------------------------------------------------
module imm_range_check
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  ImmSrc,
    input  logic [31:0] ImmIn,
    output logic        err
);

    logic signed [31:0] immSigned;
    logic               in12;
    logic               inB;
    logic               inJ;
    imm_src_t           src;

    assign immSigned = $signed(ImmIn);
    assign src       = imm_src_t'(ImmSrc);

    assign in12 = (immSigned >= IMM12_MIN) && (immSigned <= IMM12_MAX);
    // B and J encodings drop bit 0, so odd offsets cannot be represented.
    assign inB  = (immSigned >= IMMB_MIN) && (immSigned <= IMMB_MAX) && !ImmIn[0];
    assign inJ  = (immSigned >= IMMJ_MIN) && (immSigned <= IMMJ_MAX) && !ImmIn[0];

    always_comb begin
        err = 1'b1;
        case (src)
            IMM_I, IMM_S: err = !in12;
            IMM_B:        err = !inB;
            // U holds only the upper 20 bits; the low 12 must already be zero.
            IMM_U:        err = (ImmIn[11:0] != 12'd0);
            IMM_J:        err = !inJ;
            default:      err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
// Places a signed immediate into the immediate fields of a base instruction
// word (inverse of the immediate extender) and flags immediates the chosen
// format cannot represent. Two-stage valid/ready pipeline:
//   stage 1 registers the request and the range/alignment check result,
//   stage 2 registers the encoded instruction and error flag.
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : request handshake
//   ImmSrc              : [2:0] format code (000 I, 001 S, 010 B, 011 U, 100 J)
//   ImmIn               : [31:0] signed immediate
//   BaseInstr           : [31:0] instruction word; immediate bits are ignored
//   out_valid/out_ready : result handshake
//   InstrOut            : [31:0] encoded instruction
//   ImmErr              : immediate not representable or ImmSrc illegal
//   EncCount            : [CNT_W-1:0] results accepted by consumer (saturating)
//   ErrCount            : [CNT_W-1:0] accepted results with ImmErr=1 (saturating)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. While out_valid=1 and out_ready=0 the result is held unchanged.
// in_ready depends on out_ready combinationally but never on in_valid.
// -----------------------------------------------------------------------------
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ImmSrc,
    input  logic [31:0]      ImmIn,
    input  logic [31:0]      BaseInstr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      InstrOut,
    output logic             ImmErr,
    output logic [CNT_W-1:0] EncCount,
    output logic [CNT_W-1:0] ErrCount
);

    logic        rstDone;
    logic        s1Valid;
    logic [2:0]  s1Src;
    logic [31:0] s1Imm;
    logic [31:0] s1Base;
    logic        s1Err;
    logic        s2Valid;
    logic        s2CanLoad;
    logic        rangeErr;
    logic [31:0] fieldImm;
    logic [31:0] placed;

    imm_range_check uRangeCheck (
        .ImmSrc (ImmSrc),
        .ImmIn  (ImmIn),
        .err    (rangeErr)
    );

    assign s2CanLoad = !s2Valid || out_ready;
    // rstDone keeps the input closed for the first cycle after reset release.
    assign in_ready  = rstDone && (!s1Valid || s2CanLoad);
    assign out_valid = s2Valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstDone <= 1'b0;
        end else begin
            rstDone <= 1'b1;
        end
    end

    // Stage 1: capture request and its range/alignment verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            s1Src   <= 3'd0;
            s1Imm   <= 32'd0;
            s1Base  <= 32'd0;
            s1Err   <= 1'b0;
        end else if (in_ready) begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1Src  <= ImmSrc;
                s1Imm  <= ImmIn;
                s1Base <= BaseInstr;
                s1Err  <= rangeErr;
            end
        end
    end

    // Field placement. An erroring legal format gets zeroed immediate fields;
    // an illegal format passes the base word through untouched.
    always_comb begin
        fieldImm = s1Err ? 32'd0 : s1Imm;
        placed   = s1Base;
        case (imm_src_t'(s1Src))
            IMM_I: placed[31:20] = fieldImm[11:0];
            IMM_S: begin
                placed[31:25] = fieldImm[11:5];
                placed[11:7]  = fieldImm[4:0];
            end
            IMM_B: begin
                placed[31]    = fieldImm[12];
                placed[30:25] = fieldImm[10:5];
                placed[11:8]  = fieldImm[4:1];
                placed[7]     = fieldImm[11];
            end
            IMM_U: placed[31:12] = fieldImm[31:12];
            IMM_J: begin
                placed[31]    = fieldImm[20];
                placed[30:21] = fieldImm[10:1];
                placed[20]    = fieldImm[11];
                placed[19:12] = fieldImm[19:12];
            end
            default: placed = s1Base;
        endcase
    end

    // Stage 2: output register, loads only when empty or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid  <= 1'b0;
            InstrOut <= 32'd0;
            ImmErr   <= 1'b0;
        end else if (s2CanLoad) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                InstrOut <= placed;
                ImmErr   <= s1Err;
            end
        end
    end

    // Saturating statistics, counted on consumer acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EncCount <= '0;
            ErrCount <= '0;
        end else if (s2Valid && out_ready) begin
            if (EncCount != {CNT_W{1'b1}}) begin
                EncCount <= EncCount + CNT_W'(1);
            end
            if (ImmErr && (ErrCount != {CNT_W{1'b1}})) begin
                ErrCount <= ErrCount + CNT_W'(1);
            end
        end
    end

endmodule
